unsigned_sequential_multiplier: RTL and testbench

- Parametrised, multi-cycle radix-2 shift-add unsigned multiplier.
- Successor to the fixed-width combinational array multipliers in the arithmetic library; trades latency for area at wide operand widths.
- Operands are accepted with a start/done handshake, and the product is held in an output register.
- Enable gating keeps the combinational family's high-impedance output behaviour.

---
 rtl/unsigned_sequential_multiplier_if.sv | 22 ++
 rtl/unsigned_sequential_multiplier.sv | 107 ++++++++++
 tb/tb_unsigned_sequential_multiplier.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/unsigned_sequential_multiplier_if.sv
// Operand/handshake bundle for unsigned_sequential_multiplier.
// The tri-stated product stays a plain port on the multiplier itself.
interface unsigned_sequential_multiplier_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Enable_In;
    logic                  Start_In;
    logic [DATA_WIDTH-1:0] Data_A_In;
    logic [DATA_WIDTH-1:0] Data_B_In;
    logic                  Busy_Out;
    logic                  Done_Out;

    modport master (
        output Enable_In, Start_In, Data_A_In, Data_B_In,
        input  Busy_Out, Done_Out
    );

    modport slave (
        input  Enable_In, Start_In, Data_A_In, Data_B_In,
        output Busy_Out, Done_Out
    );
endinterface

// File: rtl/unsigned_sequential_multiplier.sv
// Radix-2 shift-add unsigned multiplier, W-bit operands, 2W-bit registered product.
// Optional macro EARLY_TERMINATION_EN: leave CALC once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for Start_In with Enable_In high
// CALC  | one shift-add step per cycle
// DONE  | product just loaded, Done_Out pulses for one cycle
module unsigned_sequential_multiplier #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                          Clk_In,
    input  logic                          Resetn_In,
    unsigned_sequential_multiplier_if.slave mul_if,
    output wire  [2*DATA_WIDTH-1:0]       Multiplied_Result_Out
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  res_q, res_d;
    logic [2*W-1:0]  sum;
    logic            last;

    always_ff @(posedge Clk_In or negedge Resetn_In) begin
        if (!Resetn_In) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum     = acc_q + (b_q[0] ? a_q : '0);
        last    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mul_if.Enable_In && mul_if.Start_In) begin
                    state_d = S_CALC;
                    a_d     = {{W{1'b0}}, mul_if.Data_A_In};
                    b_d     = mul_if.Data_B_In;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                acc_d = sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
`ifdef EARLY_TERMINATION_EN
                last  = (cnt_d == CNT_LAST) || (b_d == '0);
`else
                last  = (cnt_d == CNT_LAST);
`endif
                if (last) begin
                    state_d = S_DONE;
                    res_d   = sum;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable wins over everything: drop the operation, keep the last product.
        if (!mul_if.Enable_In) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    assign mul_if.Busy_Out = mul_if.Enable_In && (state_q == S_CALC);
    assign mul_if.Done_Out = mul_if.Enable_In && (state_q == S_DONE);

    assign Multiplied_Result_Out = mul_if.Enable_In ? res_q : {2*W{1'bz}};
endmodule

// File: tb/tb_unsigned_sequential_multiplier.sv
// Scoreboard bench for unsigned_sequential_multiplier (W = 8), directed vectors.
// Expected latencies follow EARLY_TERMINATION_EN when it is defined for the build.
module tb_unsigned_sequential_multiplier;
    localparam int DW = 8;

    logic            Clk_In;
    logic            Resetn_In;
    wire  [2*DW-1:0] result;

    unsigned_sequential_multiplier_if #(.DATA_WIDTH(DW)) mif ();

    unsigned_sequential_multiplier #(.DATA_WIDTH(DW)) dut (
        .Clk_In                (Clk_In),
        .Resetn_In             (Resetn_In),
        .mul_if                (mif.slave),
        .Multiplied_Result_Out (result)
    );

    initial Clk_In = 1'b0;
    always #5 Clk_In = ~Clk_In;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A disabled bus is Z in a 4-state simulator and resolves to 0 in a 2-state one.
    task automatic check_z(input string name);
        n_checks++;
        if (!(result === {2*DW{1'bz}} || result === {2*DW{1'b0}})) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected Z", name, result);
        end
    endtask

    always @(negedge Clk_In) begin
        if (Resetn_In && mif.Done_Out) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: got Done with result 0x%0h, expected no Done", result);
            end else begin
                logic [2*DW-1:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    n_errors++;
                    $display("FAIL product: got 0x%0h, expected 0x%0h", result, e);
                end
            end
        end
    end

    task automatic wait_done(output int busy_n);
        bit seen;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk_In);
            if (mif.Done_Out) seen = 1'b1;
            else if (mif.Busy_Out) busy_n++;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no Done in 40 cycles, expected Done");
        end
    endtask

    task automatic do_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2*DW-1:0] exp, input int n_et, input int n_fixed);
        int busy_n;
        int n_exp;
`ifdef EARLY_TERMINATION_EN
        n_exp = n_et;
`else
        n_exp = n_fixed;
`endif
        @(posedge Clk_In); #1;
        mif.Start_In  = 1'b1;
        mif.Data_A_In = a;
        mif.Data_B_In = b;
        exp_q.push_back(exp);
        @(posedge Clk_In); #1;
        mif.Start_In = 1'b0;
        wait_done(busy_n);
        check("busy_cycles", busy_n, n_exp);
        @(negedge Clk_In);
        check("done_fall", {31'd0, mif.Done_Out}, 32'd0);
        check("result_hold", {16'd0, result}, {16'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        Resetn_In     = 1'b0;
        mif.Enable_In = 1'b1;
        mif.Start_In  = 1'b0;
        mif.Data_A_In = '0;
        mif.Data_B_In = '0;
        repeat (2) @(negedge Clk_In);
        Resetn_In = 1'b1;
        repeat (2) @(negedge Clk_In);
        check("reset_result", {16'd0, result}, 32'd0);
        check("reset_busy", {31'd0, mif.Busy_Out}, 32'd0);
        check("reset_done", {31'd0, mif.Done_Out}, 32'd0);
        mif.Enable_In = 1'b0;
        #1;
        check_z("idle_disabled_z");
        mif.Enable_In = 1'b1;

        do_mul(8'hFF, 8'hFF, 16'hFE01, 8, 8);
        do_mul(8'h0D, 8'h03, 16'h0027, 2, 8);
        do_mul(8'h00, 8'hA5, 16'h0000, 8, 8);
        do_mul(8'hA5, 8'h00, 16'h0000, 1, 8);

        // Second Start during CALC must be ignored.
        @(posedge Clk_In); #1;
        mif.Start_In  = 1'b1;
        mif.Data_A_In = 8'h12;
        mif.Data_B_In = 8'h34;
        exp_q.push_back(16'h03A8);
        @(posedge Clk_In); #1;
        mif.Start_In = 1'b0;
        repeat (2) @(posedge Clk_In);
        #1;
        mif.Start_In  = 1'b1;
        mif.Data_A_In = 8'hFF;
        mif.Data_B_In = 8'hFF;
        @(posedge Clk_In); #1;
        mif.Start_In = 1'b0;
        wait_done(busy_n);
        @(negedge Clk_In);
        check("restart_done_fall", {31'd0, mif.Done_Out}, 32'd0);
        check("restart_result", {16'd0, result}, 32'h03A8);
        repeat (12) @(negedge Clk_In);
        check("restart_no_second", {16'd0, result}, 32'h03A8);

        // Enable dropped for one cycle mid-CALC.
        @(posedge Clk_In); #1;
        mif.Start_In  = 1'b1;
        mif.Data_A_In = 8'h55;
        mif.Data_B_In = 8'h55;
        @(posedge Clk_In); #1;
        mif.Start_In = 1'b0;
        @(posedge Clk_In); #1;
        check("abort_busy_before", {31'd0, mif.Busy_Out}, 32'd1);
        mif.Enable_In = 1'b0;
        @(negedge Clk_In);
        check_z("abort_z");
        check("abort_busy", {31'd0, mif.Busy_Out}, 32'd0);
        check("abort_done", {31'd0, mif.Done_Out}, 32'd0);
        @(posedge Clk_In); #1;
        mif.Enable_In = 1'b1;
        repeat (12) @(negedge Clk_In);
        check("abort_result_kept", {16'd0, result}, 32'h03A8);
        check("abort_idle_busy", {31'd0, mif.Busy_Out}, 32'd0);

        // Reset asserted mid-CALC.
        @(posedge Clk_In); #1;
        mif.Start_In  = 1'b1;
        mif.Data_A_In = 8'h55;
        mif.Data_B_In = 8'h55;
        @(posedge Clk_In); #1;
        mif.Start_In = 1'b0;
        @(posedge Clk_In); #1;
        Resetn_In = 1'b0;
        #1;
        check("rst_mid_result", {16'd0, result}, 32'd0);
        check("rst_mid_busy", {31'd0, mif.Busy_Out}, 32'd0);
        check("rst_mid_done", {31'd0, mif.Done_Out}, 32'd0);
        @(posedge Clk_In); #1;
        Resetn_In = 1'b1;
        repeat (12) @(negedge Clk_In);
        check("rst_mid_after", {16'd0, result}, 32'd0);

        do_mul(8'h80, 8'h02, 16'h0100, 2, 8);
        do_mul(8'h01, 8'h80, 16'h0080, 8, 8);
        do_mul(8'hC3, 8'h05, 16'h03CF, 3, 8);

        repeat (4) @(negedge Clk_In);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
